// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the integer register file.
//   Carries the legacy defines (RstEnable, WriteEnable, ReadEnable, ZeroWord,
//   NOPRegAddr, RegBus/RegAddrBus widths, RegNum/RegNumLog2) as typed
//   localparams. Imported by regfile and regfile_rd_port.
package regfile_pkg;

    localparam int RF_DATA_W   = 32;              // RegBus width
    localparam int RF_ADDR_W   = 5;               // RegAddrBus width / RegNumLog2
    localparam int RF_NUM_REGS = 1 << RF_ADDR_W;  // RegNum

    localparam logic RST_ENABLE    = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;

    localparam logic [RF_ADDR_W-1:0] NOP_REG_ADDR = '0;
    localparam logic [RF_DATA_W-1:0] ZERO_WORD    = '0;

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port of the register file.
//   Priority: reset -> 0, address 0 -> 0, same-cycle write bypass (when
//   BYPASS is set), enabled storage read, otherwise 0.
// Ports:
//   i_rst             reset active, forces 0
//   i_re / i_raddr    read enable and address
//   i_we / i_waddr / i_wdata   write-back presented this cycle (bypass source)
//   i_regs            flattened storage array
//   o_rdata           read data
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                             i_rst,
    input  logic                             i_re,
    input  logic [ADDR_W-1:0]                i_raddr,
    input  logic                             i_we,
    input  logic [ADDR_W-1:0]                i_waddr,
    input  logic [DATA_W-1:0]                i_wdata,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  i_regs,
    output logic [DATA_W-1:0]                o_rdata
);

    always_comb begin
        o_rdata = '0;
        if (i_rst == RST_ENABLE) begin
            o_rdata = '0;
        end else if (i_raddr == '0) begin
            // x0 reads zero even when a write to x0 is presented
            o_rdata = '0;
        end else if (BYPASS && i_re == READ_ENABLE && i_we == WRITE_ENABLE
                     && i_raddr == i_waddr) begin
            o_rdata = i_wdata;
        end else if (i_re == READ_ENABLE) begin
            o_rdata = i_regs[i_raddr];
        end
    end

endmodule

// File: rtl/regfile.sv
// regfile: general-purpose integer register file fed by the MEM/WB stage.
//   Two combinational read ports with same-cycle write bypass; x0 reads 0.
//   Synchronous active-high reset clears all registers and drops any write
//   presented in the reset cycle.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   we, waddr, wdata          write-back port
//   re1, raddr1 -> rdata1     read port 1
//   re2, raddr2 -> rdata2     read port 2
// Optional (macro REGFILE_DEBUG_EN):
//   dbg_raddr -> dbg_rdata    storage peek, no bypass
//   wb_count                  accepted-write counter, wraps at 2^32
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
`ifdef REGFILE_DEBUG_EN
    ,
    input  logic [ADDR_W-1:0] dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [31:0]       wb_count
`endif
);

    logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
    logic                            w_wr_acc;

    // A write lands only outside reset and never to x0.
    assign w_wr_acc = (rst != RST_ENABLE) && (we == WRITE_ENABLE) && (waddr != '0);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_regs <= '0;
        end else if (w_wr_acc) begin
            r_regs[waddr] <= wdata;
        end
    end

    regfile_rd_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .BYPASS(1'b1)
    ) u_rd1 (
        .i_rst(rst), .i_re(re1), .i_raddr(raddr1),
        .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_regs(r_regs), .o_rdata(rdata1)
    );

    regfile_rd_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .BYPASS(1'b1)
    ) u_rd2 (
        .i_rst(rst), .i_re(re2), .i_raddr(raddr2),
        .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_regs(r_regs), .o_rdata(rdata2)
    );

`ifdef REGFILE_DEBUG_EN
    logic [31:0] r_wb_count;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_wb_count <= '0;
        end else if (w_wr_acc) begin
            r_wb_count <= r_wb_count + 32'd1;  // natural wrap to 0
        end
    end

    assign wb_count = r_wb_count;

    // Debug peek shows committed storage only, so bypass is off and the
    // port is always enabled.
    regfile_rd_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .BYPASS(1'b0)
    ) u_rd_dbg (
        .i_rst(rst), .i_re(READ_ENABLE), .i_raddr(dbg_raddr),
        .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_regs(r_regs), .o_rdata(dbg_rdata)
    );
`endif

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed + randomized checks of regfile against an array model.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
`ifdef REGFILE_DEBUG_EN
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;
    logic [31:0] wb_count;
`endif

    regfile dut (
        .clk(clk), .rst(rst),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
`ifdef REGFILE_DEBUG_EN
        , .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .wb_count(wb_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural model: committed register contents and accepted-write count.
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected read result from the architectural rules.
    function automatic logic [31:0] exp_rd(input logic ren, input logic [4:0] ra);
        if (rst) return 32'h0;
        if (ra == 5'd0) return 32'h0;
        if (ren && we && ra == waddr) return wdata;
        if (ren) return m_regs[ra];
        return 32'h0;
    endfunction

    task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                         input logic [31:0] wd, input logic e1, input logic [4:0] a1,
                         input logic e2, input logic [4:0] a2);
        rst = r; we = w; waddr = wa; wdata = wd;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
        #2;
    endtask

    // Advance one clock and commit the presented write into the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_cnt = 32'h0;
        end else if (we && waddr != 5'd0) begin
            m_regs[waddr] = wdata;
            m_cnt = m_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_p1"}, rdata1, exp_rd(re1, raddr1));
        check({tag, "_p2"}, rdata2, exp_rd(re2, raddr2));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'hx;
        m_cnt = 32'hx;
`ifdef REGFILE_DEBUG_EN
        dbg_raddr = 5'd0;
`endif
        @(posedge clk); #1;

        // Reset for two cycles; reads ignore enables while reset is high.
        drive(1, 1, 5'd4, 32'h1234, 1, 5'd5, 1, 5'd31);
        check("rst_rd1", rdata1, 32'h0);
        check("rst_rd2", rdata2, 32'h0);
        tick();
        drive(1, 0, 5'd0, 32'h0, 1, 5'd5, 1, 5'd31);
        tick();
        drive(0, 0, 5'd0, 32'h0, 1, 5'd5, 1, 5'd31);
        check("post_rst_rd1", rdata1, 32'h0);
        check("post_rst_rd2", rdata2, 32'h0);
        tick();

        // Write then read, and enable low forces 0.
        drive(0, 1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 0, 5'd0);
        tick();
        drive(0, 0, 5'd0, 32'h0, 1, 5'd3, 0, 5'd3);
        check("wr_rd", rdata1, 32'hDEADBEEF);
        check("re_off", rdata2, 32'h0);
        tick();

        // x0 stays zero even with a bypass-looking write.
        drive(0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 1, 5'd0);
        check("x0_same", rdata1, 32'h0);
        tick();
        drive(0, 0, 5'd0, 32'h0, 1, 5'd0, 1, 5'd3);
        check("x0_next", rdata1, 32'h0);
        check("x3_keep", rdata2, 32'hDEADBEEF);
        tick();

        // Bypass on both ports at once.
        drive(0, 1, 5'd7, 32'h11, 0, 5'd0, 0, 5'd0);
        tick();
        drive(0, 1, 5'd7, 32'h22, 1, 5'd7, 1, 5'd7);
        check("byp_p1", rdata1, 32'h22);
        check("byp_p2", rdata2, 32'h22);
        tick();
        drive(0, 0, 5'd7, 32'h0, 1, 5'd7, 1, 5'd7);
        check("byp_store", rdata1, 32'h22);
        tick();

        // Reset mid-stream drops the in-flight write.
        drive(0, 1, 5'd9, 32'h55, 0, 5'd0, 0, 5'd0);
        tick();
        drive(1, 1, 5'd9, 32'h66, 1, 5'd9, 1, 5'd9);
        check("mid_rst_rd", rdata1, 32'h0);
        tick();
        drive(0, 0, 5'd0, 32'h0, 1, 5'd9, 1, 5'd3);
        check("after_rst_r9", rdata1, 32'h0);
        check("after_rst_r3", rdata2, 32'h0);
        tick();

`ifdef REGFILE_DEBUG_EN
        // Counter and debug peek: 4 writes to x10 plus one ignored write to x0.
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 5'd10, 32'hA000 + k, 0, 5'd0, 0, 5'd0);
            tick();
        end
        drive(0, 1, 5'd0, 32'hBAD, 0, 5'd0, 0, 5'd0);
        tick();
        dbg_raddr = 5'd10;
        drive(0, 1, 5'd10, 32'h7777, 0, 5'd0, 0, 5'd0);
        check("wb_count4", wb_count, 32'd4);
        check("dbg_nobyp", dbg_rdata, 32'hA003);
        dbg_raddr = 5'd0;
        #1;
        check("dbg_x0", dbg_rdata, 32'h0);
        drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0);
        force dut.r_wb_count = 32'hFFFFFFFF;
        #1;
        release dut.r_wb_count;
        m_cnt = 32'hFFFFFFFF;
        drive(0, 1, 5'd12, 32'h1, 0, 5'd0, 0, 5'd0);
        tick();
        check("wb_wrap", wb_count, 32'h0);
        check("wb_wrap_mdl", wb_count, m_cnt);
`endif

        // Randomized traffic against the model; reads often target the write
        // address to exercise bypass.
        for (int c = 0; c < 400; c++) begin
            logic        r, w, e1, e2;
            logic [4:0]  wa, a1, a2;
            logic [31:0] wd;
            r  = ($urandom_range(0, 31) == 0);
            w  = ($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            e1 = ($urandom_range(0, 7) != 0);
            e2 = ($urandom_range(0, 7) != 0);
            a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            drive(r, w, wa, wd, e1, a1, e2, a2);
            check_model("rand");
`ifdef REGFILE_DEBUG_EN
            check("rand_cnt", wb_count, m_cnt);
`endif
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
